// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a 4-entry first-word-fall-through byte FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       UartRxWire,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       FrameError,
    output logic       Overrun,
    output logic [2:0] Count
);

    localparam int              TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]   HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]      FULL     = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic [7:0]    mem_q [4];
    logic          push, pop, full, wr_en;
    logic          rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in so short glitches are ignored.
                if (timer_q == HALF_END) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    shift_d[bit_idx_q] = rx_s;
                    timer_d            = '0;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    push        = rx_s;
                    frame_err_d = !rx_s;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        pop       = (count_q != 3'd0) && RxReady;
        full      = (count_q == FULL);
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        count_d   = count_q + 3'(wr_en) - 3'(pop);
        wr_ptr_d  = wr_ptr_q + 2'(wr_en);
        rd_ptr_d  = rd_ptr_q + 2'(pop);
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            sync1_q     <= UartRxWire;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mem
        always_ff @(posedge Clk) begin
            if (!ResetN) begin
                mem_q[gi] <= 8'h00;
            end else if (wr_en && (wr_ptr_q == 2'(gi))) begin
                mem_q[gi] <= shift_q;
            end
        end
    end

    assign RxData     = mem_q[rd_ptr_q];
    assign RxValid    = (count_q != 3'd0);
    assign Count      = count_q;
    assign FrameError = frame_err_q;
    assign Overrun    = overrun_q;

endmodule
